// File: rtl/interval_timer.sv
// Up-counting interval timer with one-shot / periodic modes, retrigger and abort.
// Optional tick prescaler enabled by defining INTERVAL_TIMER_PRESCALE_EN.
module interval_timer #(
    parameter int WIDTH        = 16,
    parameter int PERIOD_CNT_W = 8,
    parameter int PRESCALE_W   = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    start_i,
    input  logic                    stop_i,
    input  logic                    mode_i,
    input  logic [WIDTH-1:0]        limit_i,
`ifdef INTERVAL_TIMER_PRESCALE_EN
    input  logic [PRESCALE_W-1:0]   prescale_i,
`endif
    output logic                    busy_o,
    output logic                    done_o,
    output logic [WIDTH-1:0]        count_o,
    output logic [PERIOD_CNT_W-1:0] period_cnt_o
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  state_r, state_s;
    logic [WIDTH-1:0]        limit_r, limit_s;
    logic                    mode_r, mode_s;
    logic [WIDTH-1:0]        count_r, count_s;
    logic [PERIOD_CNT_W-1:0] period_cnt_r, period_cnt_s;
    logic                    busy_r, busy_s;
    logic                    done_r, done_s;
    logic                    tick_s;
    logic                    start_s;

    // Completion counter sticks at all-ones instead of wrapping.
    function automatic logic [PERIOD_CNT_W-1:0] sat_inc(input logic [PERIOD_CNT_W-1:0] v);
        logic [PERIOD_CNT_W-1:0] r;
        if (v == {PERIOD_CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(PERIOD_CNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    // A start is honoured only when no abort arrives in the same cycle.
    always_comb begin
        start_s = start_i & ~stop_i;
    end

`ifdef INTERVAL_TIMER_PRESCALE_EN
    logic [PRESCALE_W-1:0] prescale_r;
    logic [PRESCALE_W-1:0] presc_r, presc_s;

    // Tick whenever the prescaler reaches the latched divider value.
    always_comb begin
        tick_s = (presc_r == prescale_r);
    end

    // Prescaler restarts on start, on every tick and outside RUN.
    always_comb begin
        presc_s = {PRESCALE_W{1'b0}};
        if ((state_r == ST_RUN) && !stop_i && !start_i && !tick_s) begin
            presc_s = presc_r + {{(PRESCALE_W-1){1'b0}}, 1'b1};
        end else begin
            presc_s = {PRESCALE_W{1'b0}};
        end
    end

    // Prescaler and latched divider registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            presc_r    <= {PRESCALE_W{1'b0}};
            prescale_r <= {PRESCALE_W{1'b0}};
        end else begin
            presc_r <= presc_s;
            if (start_s) begin
                prescale_r <= prescale_i;
            end
        end
    end
`else
    // Without the prescaler every RUN cycle is a tick.
    always_comb begin
        tick_s = 1'b1;
    end
`endif

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state and next datapath values; stop > start > terminal > advance.
    always_comb begin
        state_s      = state_r;
        limit_s      = limit_r;
        mode_s       = mode_r;
        count_s      = count_r;
        period_cnt_s = period_cnt_r;
        busy_s       = busy_r;
        done_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_s      = ST_RUN;
                    limit_s      = limit_i;
                    mode_s       = mode_i;
                    count_s      = {WIDTH{1'b0}};
                    period_cnt_s = {PERIOD_CNT_W{1'b0}};
                    busy_s       = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (stop_i) begin
                    state_s = ST_IDLE;
                    busy_s  = 1'b0;
                end else if (start_i) begin
                    // Retrigger suppresses a terminal tick landing on the same edge.
                    limit_s      = limit_i;
                    mode_s       = mode_i;
                    count_s      = {WIDTH{1'b0}};
                    period_cnt_s = {PERIOD_CNT_W{1'b0}};
                    busy_s       = 1'b1;
                end else if (tick_s) begin
                    if (count_r == limit_r) begin
                        done_s = 1'b1;
                        if (mode_r) begin
                            count_s      = {WIDTH{1'b0}};
                            period_cnt_s = sat_inc(period_cnt_r);
                        end else begin
                            state_s = ST_IDLE;
                            busy_s  = 1'b0;
                        end
                    end else begin
                        count_s = count_r + {{(WIDTH-1){1'b0}}, 1'b1};
                    end
                end else begin
                    count_s = count_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            limit_r      <= {WIDTH{1'b0}};
            mode_r       <= 1'b0;
            count_r      <= {WIDTH{1'b0}};
            period_cnt_r <= {PERIOD_CNT_W{1'b0}};
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            limit_r      <= limit_s;
            mode_r       <= mode_s;
            count_r      <= count_s;
            period_cnt_r <= period_cnt_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
        end
    end

    assign busy_o       = busy_r;
    assign done_o       = done_r;
    assign count_o      = count_r;
    assign period_cnt_o = period_cnt_r;

endmodule

// File: tb/tb_interval_timer.sv
// Self-checking bench for interval_timer: directed scenarios then random
// start/stop traffic, compared every cycle against an elapsed-tick model.
module tb_interval_timer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic        mode;
    logic [15:0] limit;
    logic [7:0]  prescale;
    logic        busy;
    logic        done;
    logic [15:0] count;
    logic [7:0]  period_cnt;

    int total = 0;
    int bad   = 0;
    int ndone = 0;

    // Model: elapsed cycles since start, converted to ticks with division.
    bit     m_run, m_busy, m_done, m_mode;
    longint m_lim, m_presc, m_cyc, m_cnt, m_per;

    always #5 clk = ~clk;

    interval_timer dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .start_i      (start),
        .stop_i       (stop),
        .mode_i       (mode),
        .limit_i      (limit),
`ifdef INTERVAL_TIMER_PRESCALE_EN
        .prescale_i   (prescale),
`endif
        .busy_o       (busy),
        .done_o       (done),
        .count_o      (count),
        .period_cnt_o (period_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_busy = 0; m_done = 0; m_mode = 0;
        m_lim = 0; m_presc = 0; m_cyc = 0; m_cnt = 0; m_per = 0;
    endtask

    task automatic model_edge(input bit st, input bit sp, input bit md,
                              input longint lim, input longint ps);
        longint t, n;
        m_done = 0;
        if (sp) begin
            if (m_run) begin
                m_run  = 0;
                m_busy = 0;
            end
        end else if (st) begin
            m_lim = lim; m_mode = md;
`ifdef INTERVAL_TIMER_PRESCALE_EN
            m_presc = ps;
`else
            m_presc = 0;
`endif
            m_cyc = 0; m_run = 1; m_busy = 1; m_cnt = 0; m_per = 0;
        end else if (m_run) begin
            m_cyc++;
            if (m_cyc % (m_presc + 1) == 0) begin
                t = m_cyc / (m_presc + 1);
                n = m_lim + 1;
                if (!m_mode) begin
                    if (t == n) begin
                        m_done = 1; m_run = 0; m_busy = 0; m_cnt = m_lim;
                    end else begin
                        m_cnt = t;
                    end
                end else begin
                    m_cnt  = t % n;
                    m_done = (t % n == 0);
                    m_per  = (t / n > 255) ? 255 : t / n;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".busy"}, {31'd0, busy}, {31'd0, m_busy});
        chk({tag, ".done"}, {31'd0, done}, {31'd0, m_done});
        chk({tag, ".count"}, {16'd0, count}, m_cnt[31:0]);
        chk({tag, ".pcnt"}, {24'd0, period_cnt}, m_per[31:0]);
    endtask

    // One clock: drive inputs, advance model on the edge, sample 1 time unit later.
    task automatic cyc(input bit st, input bit sp, input bit md,
                       input logic [15:0] lim, input logic [7:0] ps, input string tag);
        start = st; stop = sp; mode = md; limit = lim; prescale = ps;
        @(posedge clk);
        model_edge(st, sp, md, longint'(lim), longint'(ps));
        #1;
        if (done) ndone++;
        check_all(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 16'd0, 8'd0, tag);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0;
        limit = 16'd0; prescale = 8'd0;
        model_reset();
        #1;
        check_all("reset");
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        idle(2, "post_reset");

        // One-shot L=5.
        cyc(1'b1, 1'b0, 1'b0, 16'd5, 8'd0, "t1_start");
        ndone = 0;
        for (int i = 1; i <= 6; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 16'd9, 8'd0, "t1_run");
            if (i == 5) chk("t1_busy_c5", {31'd0, busy}, 32'd1);
        end
        chk("t1_done_c6", {31'd0, done}, 32'd1);
        chk("t1_hold", {16'd0, count}, 32'd5);
        idle(3, "t1_after");
        chk("t1_ndone", ndone, 32'd1);

        // Periodic L=3, three periods then stop.
        cyc(1'b1, 1'b0, 1'b1, 16'd3, 8'd0, "t2_start");
        ndone = 0;
        for (int i = 1; i <= 12; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 16'd1, 8'd0, "t2_run");
            if (i % 4 == 0) chk("t2_pcnt", {24'd0, period_cnt}, i / 4);
        end
        chk("t2_ndone", ndone, 32'd3);
        cyc(1'b0, 1'b1, 1'b0, 16'd0, 8'd0, "t2_stop");
        chk("t2_busy_after_stop", {31'd0, busy}, 32'd0);
        ndone = 0;
        idle(8, "t2_after");
        chk("t2_no_done", ndone, 32'd0);

        // Retrigger at count 4, then start+stop together.
        cyc(1'b1, 1'b0, 1'b0, 16'd10, 8'd0, "t3_start");
        idle(4, "t3_run");
        chk("t3_count4", {16'd0, count}, 32'd4);
        cyc(1'b1, 1'b0, 1'b0, 16'd10, 8'd0, "t3_retrig");
        chk("t3_count0", {16'd0, count}, 32'd0);
        ndone = 0;
        idle(10, "t3_run2");
        chk("t3_no_early_done", ndone, 32'd0);
        idle(1, "t3_term");
        chk("t3_done_c11", {31'd0, done}, 32'd1);
        cyc(1'b1, 1'b1, 1'b0, 16'd7, 8'd0, "t3_both");
        chk("t3_both_idle", {31'd0, busy}, 32'd0);
        // Retrigger landing on a terminal tick.
        cyc(1'b1, 1'b0, 1'b0, 16'd2, 8'd0, "t3b_start");
        idle(2, "t3b_run");
        ndone = 0;
        cyc(1'b1, 1'b0, 1'b0, 16'd2, 8'd0, "t3b_retrig_term");
        chk("t3b_no_done", ndone, 32'd0);
        idle(2, "t3b_run2");
        cyc(1'b1, 1'b1, 1'b0, 16'd2, 8'd0, "t3b_both_run");
        chk("t3b_stop_holds", {16'd0, count}, 32'd2);

        // L=0 one-shot and periodic saturation.
        cyc(1'b1, 1'b0, 1'b0, 16'd0, 8'd0, "t4_start");
        idle(1, "t4_c1");
        chk("t4_done", {31'd0, done}, 32'd1);
        cyc(1'b1, 1'b0, 1'b1, 16'd0, 8'd0, "t4p_start");
        idle(300, "t4p_run");
        chk("t4_sat", {24'd0, period_cnt}, 32'd255);
        cyc(1'b0, 1'b1, 1'b0, 16'd0, 8'd0, "t4p_stop");

        // Async reset mid-run.
        cyc(1'b1, 1'b0, 1'b0, 16'd20, 8'd0, "t5_start");
        idle(7, "t5_run");
        chk("t5_count7", {16'd0, count}, 32'd7);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("t5_async");
        #2 rst_n = 1'b1;
        ndone = 0;
        idle(30, "t5_idle");
        chk("t5_no_done", ndone, 32'd0);

`ifdef INTERVAL_TIMER_PRESCALE_EN
        cyc(1'b1, 1'b0, 1'b0, 16'd3, 8'd2, "t6_start");
        ndone = 0;
        idle(12, "t6_run");
        chk("t6_done_c12", {31'd0, done}, 32'd1);
        chk("t6_ndone", ndone, 32'd1);
`endif

        // Random start/stop/mode/limit traffic.
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 15) == 0), ($urandom_range(0, 40) == 0),
                1'($urandom_range(0, 1)), 16'($urandom_range(0, 12)),
                8'($urandom_range(0, 3)), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
